// File: rtl/adder_sequencer.sv
// adder_sequencer: feeds one operand pair to a dynamic adder, waits a
// data-dependent budget, then holds the result. Option: ADDER_SEQUENCER_STATS_EN.
module adder_sequencer #(
    parameter int F_CYCLES = 2,
    parameter int Q_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_cin,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    output logic        add_f,
    output logic        add_request,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_cout,
`ifdef ADDER_SEQUENCER_STATS_EN
    output logic [15:0] stat_ops,
    output logic [31:0] stat_busy,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [5:0] F6 = 6'(F_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [5:0]  r_budget;
    logic [15:0] r_add_a;
    logic [15:0] r_add_b;
    logic        r_add_cin;
    logic [15:0] r_out_sum;
    logic        r_out_cout;

    logic [15:0] w_p;
    logic [2:0]  w_nq;
    logic [5:0]  w_budget;
    logic        w_accept;
    logic        w_cnt_one;

    // Carry chains crossing nibble pairs where both bits propagate
    // each cost one extra quarter of settling time.
    assign w_p      = in_a ^ in_b;
    assign w_nq     = 3'd1
                    + {2'b00, w_p[3]  & w_p[4]}
                    + {2'b00, w_p[7]  & w_p[8]}
                    + {2'b00, w_p[11] & w_p[12]};
    assign w_budget = 6'(32'(w_nq) * Q_CYCLES);
    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_cnt_one = (r_cnt == 6'd1);

    assign add_a    = r_add_a;
    assign add_b    = r_add_b;
    assign add_cin  = r_add_cin;
    assign out_sum  = r_out_sum;
    assign out_cout = r_out_cout;
    assign busy     = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        add_f       = 1'b0;
        add_request = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                add_f    = 1'b1;
                if (in_valid) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                add_f = 1'b1;
                if (w_cnt_one) w_next = S_WAIT;
            end
            S_WAIT: begin
                add_request = 1'b1;
                if (w_cnt_one) w_next = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                add_f     = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, phase counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_budget   <= '0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_add_cin  <= 1'b0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
        end else if (w_accept) begin
            r_add_a   <= in_a;
            r_add_b   <= in_b;
            r_add_cin <= in_cin;
            r_budget  <= w_budget;
            r_cnt     <= F6;
        end else if (r_state == S_LAUNCH) begin
            r_cnt <= w_cnt_one ? r_budget : r_cnt - 6'd1;
        end else if (r_state == S_WAIT) begin
            if (w_cnt_one) begin
                r_out_sum  <= add_sum;
                r_out_cout <= add_cout;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt - 6'd1;
            end
        end
    end

`ifdef ADDER_SEQUENCER_STATS_EN
    logic [15:0] r_stat_ops;
    logic [31:0] r_stat_busy;

    assign stat_ops  = r_stat_ops;
    assign stat_busy = r_stat_busy;

    // Saturating counts of completed results and busy cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ops  <= '0;
            r_stat_busy <= '0;
        end else begin
            if (out_valid && out_ready && (r_stat_ops != 16'hFFFF))
                r_stat_ops <= r_stat_ops + 16'd1;
            if (busy && (r_stat_busy != 32'hFFFF_FFFF))
                r_stat_busy <= r_stat_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_sequencer.sv
// tb_adder_sequencer: timeline model of the sequencer checked every
// cycle, plus directed operations with hand-computed results.
module tb_adder_sequencer;

    localparam int F = 2;
    localparam int Q = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic        add_f;
    logic        add_request;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;
`ifdef ADDER_SEQUENCER_STATS_EN
    logic [15:0] stat_ops;
    logic [31:0] stat_busy;
`endif

    int n_vec = 0;
    int n_err = 0;

    adder_sequencer #(.F_CYCLES(F), .Q_CYCLES(Q)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_f(add_f), .add_request(add_request),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
`ifdef ADDER_SEQUENCER_STATS_EN
        .stat_ops(stat_ops), .stat_busy(stat_busy),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Dynamic adder stand-in: the result is only right while requested
    logic [16:0] w_true;
    assign w_true   = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    assign add_sum  = add_request ? w_true[15:0] : ~w_true[15:0];
    assign add_cout = add_request ? w_true[16] : ~w_true[16];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int budget(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        int nq;
        p  = a ^ b;
        nq = 1;
        for (int k = 3; k <= 11; k += 4)
            if (p[k] && p[k+1]) nq++;
        return nq * Q;
    endfunction

    // Model: an op occupies cycles 1..F launching, F+1..F+B waiting,
    // then F+B+1 onward holding until out_ready is seen.
    logic        m_busy = 1'b0;
    int          m_t = 0;
    int          m_b = 0;
    logic [15:0] m_a = '0;
    logic [15:0] m_bo = '0;
    logic        m_cin = 1'b0;
    logic [16:0] m_res = '0;
    int          m_ops = 0;
    int          m_busyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_t     <= 0;
            m_b     <= 0;
            m_a     <= '0;
            m_bo    <= '0;
            m_cin   <= 1'b0;
            m_res   <= '0;
            m_ops   <= 0;
            m_busyc <= 0;
        end else begin
            if (m_busy) m_busyc <= m_busyc + 1;
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy <= 1'b1;
                    m_t    <= 1;
                    m_b    <= budget(in_a, in_b);
                    m_a    <= in_a;
                    m_bo   <= in_b;
                    m_cin  <= in_cin;
                end
            end else if (m_t == F + m_b + 1) begin
                if (out_ready) begin
                    m_busy <= 1'b0;
                    m_t    <= 0;
                    m_ops  <= m_ops + 1;
                end
            end else begin
                m_t <= m_t + 1;
                if (m_t + 1 == F + m_b + 1)
                    m_res <= {1'b0, m_a} + {1'b0, m_bo} + {16'd0, m_cin};
            end
        end
    end

    logic e_hold, e_wait, e_launch;
    always_comb begin
        e_hold   = m_busy && (m_t == F + m_b + 1);
        e_launch = m_busy && (m_t <= F);
        e_wait   = m_busy && !e_hold && !e_launch;
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(!m_busy));
        check("busy", 32'(busy), 32'(m_busy));
        check("add_f", 32'(add_f), 32'(!m_busy || e_launch || e_hold));
        check("add_request", 32'(add_request), 32'(e_wait));
        check("out_valid", 32'(out_valid), 32'(e_hold));
        check("out_res", 32'({out_cout, out_sum}), 32'(m_res));
        check("add_ops", 32'({add_cin, add_a, add_b}), {m_cin, m_a, m_bo});
`ifdef ADDER_SEQUENCER_STATS_EN
        check("stat_ops", 32'(stat_ops), 32'(m_ops));
        check("stat_busy", stat_busy, 32'(m_busyc));
`endif
    end

    logic [16:0] got[$];
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) got.push_back({out_cout, out_sum});
    end

    // Runs one op starting just after a negedge; ends at a negedge in IDLE
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic c, input int hold_n,
                          output int lat, output int nf, output int nr,
                          output logic [16:0] res);
        int k;
        lat = -1; nf = 0; nr = 0; res = '0;
        out_ready = (hold_n == 0);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = 1'b1;
        k = 1;
        while (!out_valid && k < 200) begin
            nf += int'(add_f);
            nr += int'(add_request);
            in_valid = k[0];
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            check("result_timeout", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            return;
        end
        lat = k;
        res = {out_cout, out_sum};
        for (int h = 0; h < hold_n; h++) begin
            @(negedge clk);
            check("hold_res", 32'({out_cout, out_sum}), 32'(res));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int lat, nf, nr, idx, n_acc;
        logic [16:0] res;
        logic pend;
        logic [15:0] va[3];
        logic [15:0] vb[3];
        logic        vc[3];
        logic [16:0] ve[3];

        va = '{16'h1234, 16'h00FF, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h8000};
        vc = '{1'b0, 1'b1, 1'b0};
        ve = '{17'h01235, 17'h00101, 17'h10000};

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_add_f", 32'(add_f), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out", 32'({out_valid, out_cout, out_sum}), 32'd0);
        rst = 1'b0;

        run_op(16'h0000, 16'h0000, 1'b0, 0, lat, nf, nr, res);
        check("zero_latency", 32'(lat), 32'd6);
        check("zero_result", 32'(res), 32'h00000);

        run_op(16'hFFFF, 16'h0000, 1'b1, 0, lat, nf, nr, res);
        check("ffff_add_f_cycles", 32'(nf), 32'd2);
        check("ffff_request_cycles", 32'(nr), 32'd12);
        check("ffff_latency", 32'(lat), 32'd15);
        check("ffff_result", 32'(res), 32'h10000);

        run_op(16'h0018, 16'h0000, 1'b0, 5, lat, nf, nr, res);
        check("b0_latency", 32'(lat), 32'd9);
        check("b0_result", 32'(res), 32'h00018);

        in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_wait", 32'(add_request), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_request", 32'(add_request), 32'd0);
        check("abort_add_f", 32'(add_f), 32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_ops", 32'({add_cin, add_a, add_b}), 32'd0);
        check("abort_out", 32'({out_valid, out_cout, out_sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end

        run_op(16'h0001, 16'h0001, 1'b0, 0, lat, nf, nr, res);
        check("post_abort_latency", 32'(lat), 32'd6);
        check("post_abort_result", 32'(res), 32'h00002);

        got.delete();
        out_ready = 1'b1;
        idx = 0; n_acc = 0; pend = 1'b0;
        in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; in_cin = vc[0];
        for (int c = 0; c < 300 && got.size() < 3; c++) begin
            if (pend) begin
                n_acc++;
                idx++;
                if (idx < 3) begin
                    in_a = va[idx]; in_b = vb[idx]; in_cin = vc[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            pend = in_valid && in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < got.size()) check("b2b_result", 32'(got[i]), 32'(ve[i]));

`ifdef ADDER_SEQUENCER_STATS_EN
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            run_op(16'h0000, 16'h0000, 1'b0, 0, lat, nf, nr, res);
        check("stat_ops_lit", 32'(stat_ops), 32'd3);
        check("stat_busy_lit", stat_busy, 32'd18);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
